// File: rtl/wb_initiator.sv
// wb_initiator: Wishbone classic single-transfer initiator.
//
// Accepts one load/store from a core-side request port, runs one Wishbone
// classic cycle and returns aligned, sign/zero-extended read data.
// Misaligned requests are rejected without a bus cycle, and a responder
// that never answers is aborted after TIMEOUT_CYCLES cycles (0 disables).
//
// Handshakes: a request transfers on a rising clk edge where
// req_valid && req_ready. req_ready is high only in IDLE. resp_valid is a
// single-cycle pulse, and resp_err / resp_rdata are meaningful only while
// it is high. On the bus, wb_stb_o mirrors wb_cyc_o, and adr/sel/dat/we
// hold steady from the first cycle of cyc until ack/err/timeout ends it.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_*               core request (valid/ready, we, addr, size,
//                       unsigned, wdata)
//   resp_*              core response (valid pulse, rdata, err)
//   wb_*                Wishbone classic initiator signals
//   dbg_state_o         current FSM state (0 IDLE, 1 BUS, 2 RESP)
module wb_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [29:0] wb_adr_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [31:0] TO_LAST = TIMEOUT_CYCLES - 1;

  state_t      state_q, state_d;
  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [29:0] adr_q, adr_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] dat_q, dat_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] cnt_q, cnt_d;

  logic        misaligned;
  logic [3:0]  lane_sel;
  logic [31:0] lane_dat;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_ext;
  logic        timeout_hit;

  // Lane selects and replicated write data for the incoming request.
  always_comb begin
    misaligned = 1'b0;
    lane_sel   = 4'b1111;
    lane_dat   = req_wdata;
    case (req_size)
      2'd0: begin
        lane_sel = 4'b0001 << req_addr[1:0];
        lane_dat = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        misaligned = req_addr[0];
        lane_sel   = req_addr[1] ? 4'b1100 : 4'b0011;
        lane_dat   = {2{req_wdata[15:0]}};
      end
      2'd2: begin
        misaligned = (req_addr[1:0] != 2'd0);
      end
      default: begin
        misaligned = 1'b1;
      end
    endcase
  end

  // Pick the addressed byte/half out of the bus word, then extend it.
  always_comb begin
    ld_b = wb_dat_i[{off_q, 3'b000} +: 8];
    ld_h = off_q[1] ? wb_dat_i[31:16] : wb_dat_i[15:0];
    case (size_q)
      2'd0:    ld_ext = uns_q ? {24'd0, ld_b} : {{24{ld_b[7]}}, ld_b};
      2'd1:    ld_ext = uns_q ? {16'd0, ld_h} : {{16{ld_h[15]}}, ld_h};
      default: ld_ext = wb_dat_i;
    endcase
  end

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);

  always_comb begin
    state_d      = state_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    cyc_d        = cyc_q;
    we_d         = we_q;
    adr_d        = adr_q;
    sel_d        = sel_q;
    dat_d        = dat_q;
    size_d       = size_q;
    uns_d        = uns_q;
    off_d        = off_q;
    cnt_d        = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          size_d      = req_size;
          uns_d       = req_unsigned;
          off_d       = req_addr[1:0];
          if (misaligned) begin
            // Rejected without touching the bus.
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = 32'd0;
          end else begin
            state_d = S_BUS;
            cyc_d   = 1'b1;
            we_d    = req_we;
            adr_d   = req_addr[31:2];
            sel_d   = lane_sel;
            dat_d   = req_we ? lane_dat : 32'd0;
            cnt_d   = 32'd0;
          end
        end
      end
      S_BUS: begin
        cnt_d = cnt_q + 32'd1;
        // err wins over ack; timeout only when the responder is silent.
        if (wb_err_i || wb_ack_i || timeout_hit) begin
          state_d      = S_RESP;
          cyc_d        = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = wb_err_i || !wb_ack_i;
          resp_rdata_d = (!wb_err_i && wb_ack_i && !we_q) ? ld_ext : 32'd0;
        end
      end
      S_RESP: begin
        state_d      = S_IDLE;
        req_ready_d  = 1'b1;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = 32'd0;
      end
      default: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
      cyc_q        <= 1'b0;
      we_q         <= 1'b0;
      adr_q        <= 30'd0;
      sel_q        <= 4'd0;
      dat_q        <= 32'd0;
      size_q       <= 2'd0;
      uns_q        <= 1'b0;
      off_q        <= 2'd0;
      cnt_q        <= 32'd0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      cyc_q        <= cyc_d;
      we_q         <= we_d;
      adr_q        <= adr_d;
      sel_q        <= sel_d;
      dat_q        <= dat_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      off_q        <= off_d;
      cnt_q        <= cnt_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign resp_valid  = resp_valid_q;
  assign resp_rdata  = resp_rdata_q;
  assign resp_err    = resp_err_q;
  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = cyc_q;
  assign wb_we_o     = we_q;
  assign wb_adr_o    = adr_q;
  assign wb_sel_o    = sel_q;
  assign wb_dat_o    = dat_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_wb_initiator.sv
module tb_wb_initiator;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [29:0] wb_adr_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;
  logic [1:0]  dbg_state_o;

  int n_vec;
  int n_err;

  // responder behaviour: 0 ack, 1 silent, 2 ack+err together, 3 err
  int          rsp_mode;
  logic [31:0] rsp_data;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  wb_initiator #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .dbg_state_o(dbg_state_o)
  );

  // Registered responder: answers one cycle after it first sees stb.
  assign wb_dat_i = rsp_data;
  always @(posedge clk) begin
    if (rst) begin
      wb_ack_i <= 1'b0;
      wb_err_i <= 1'b0;
    end else begin
      wb_ack_i <= 1'b0;
      wb_err_i <= 1'b0;
      if (wb_cyc_o && wb_stb_o && !wb_ack_i && !wb_err_i) begin
        case (rsp_mode)
          0: wb_ack_i <= 1'b1;
          2: begin wb_ack_i <= 1'b1; wb_err_i <= 1'b1; end
          3: wb_err_i <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives one request from IDLE, checks the bus phase (exp_cyc = number of
  // cycles cyc must be high, 0 = no bus cycle), latency and response.
  task automatic xfer(input string tag, input logic we, input logic [31:0] addr,
                      input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                      input int exp_cyc, input logic [3:0] exp_sel,
                      input logic [31:0] exp_dat, input int exp_lat,
                      input logic [31:0] exp_rdata, input logic exp_err);
    int   lat;
    int   cyc_cnt;
    logic got;
    chk({tag, ".ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
    req_unsigned = uns; req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0;
    if (exp_cyc > 0) begin
      chk({tag, ".cyc"}, {30'd0, wb_cyc_o, wb_stb_o}, 32'd3);
      chk({tag, ".we"},  {31'd0, wb_we_o}, {31'd0, we});
      chk({tag, ".adr"}, {2'd0, wb_adr_o}, {2'd0, addr[31:2]});
      chk({tag, ".sel"}, {28'd0, wb_sel_o}, {28'd0, exp_sel});
      chk({tag, ".dat"}, wb_dat_o, exp_dat);
    end
    lat = 1; cyc_cnt = 0; got = 1'b0;
    while (!got && lat <= 20) begin
      if (wb_cyc_o) cyc_cnt++;
      if (resp_valid) got = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    chk({tag, ".lat"}, lat, exp_lat);
    chk({tag, ".ncyc"}, cyc_cnt, exp_cyc);
    chk({tag, ".rdata"}, resp_rdata, exp_rdata);
    chk({tag, ".err"}, {31'd0, resp_err}, {31'd0, exp_err});
    @(negedge clk);
    chk({tag, ".post"}, {29'd0, resp_valid, req_ready, wb_cyc_o}, 32'b010);
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rsp_mode = 0; rsp_data = 32'h0;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0;
    req_size = 2'd0; req_unsigned = 1'b0; req_wdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst.ready", {31'd0, req_ready}, 32'd1);
    chk("rst.outs", {28'd0, resp_valid, resp_err, wb_cyc_o, wb_stb_o}, 32'd0);
    chk("rst.bus", {wb_we_o, wb_adr_o, 1'b0} | {28'd0, wb_sel_o}, 32'd0);
    chk("rst.dat", wb_dat_o | resp_rdata, 32'd0);
    chk("rst.state", {30'd0, dbg_state_o}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // word store
    xfer("wstore", 1'b1, 32'h1000_0004, 2'd2, 1'b0, 32'hDEAD_BEEF,
         2, 4'b1111, 32'hDEAD_BEEF, 3, 32'h0, 1'b0);
    // loads from 0x80AA_5511
    rsp_data = 32'h80AA_5511;
    xfer("lb3s", 1'b0, 32'h2000_0003, 2'd0, 1'b0, 32'h0,
         2, 4'b1000, 32'h0, 3, 32'hFFFF_FF80, 1'b0);
    xfer("lb3u", 1'b0, 32'h2000_0003, 2'd0, 1'b1, 32'h0,
         2, 4'b1000, 32'h0, 3, 32'h0000_0080, 1'b0);
    xfer("lb1s", 1'b0, 32'h2000_0001, 2'd0, 1'b0, 32'h0,
         2, 4'b0010, 32'h0, 3, 32'h0000_0055, 1'b0);
    xfer("lh2s", 1'b0, 32'h2000_0002, 2'd1, 1'b0, 32'h0,
         2, 4'b1100, 32'h0, 3, 32'hFFFF_80AA, 1'b0);
    xfer("lh0u", 1'b0, 32'h2000_0000, 2'd1, 1'b1, 32'h0,
         2, 4'b0011, 32'h0, 3, 32'h0000_5511, 1'b0);
    xfer("lw", 1'b0, 32'h2000_0008, 2'd2, 1'b0, 32'h0,
         2, 4'b1111, 32'h0, 3, 32'h80AA_5511, 1'b0);
    // stores of narrow widths
    xfer("hstore", 1'b1, 32'h3000_0002, 2'd1, 1'b0, 32'h0000_1234,
         2, 4'b1100, 32'h1234_1234, 3, 32'h0, 1'b0);
    xfer("bstore", 1'b1, 32'h3000_0001, 2'd0, 1'b0, 32'h0000_00AB,
         2, 4'b0010, 32'hABAB_ABAB, 3, 32'h0, 1'b0);
    // misaligned / illegal size: no bus cycle, error one cycle after accept
    xfer("mis.h1", 1'b0, 32'h3000_0001, 2'd1, 1'b0, 32'h0,
         0, 4'b0000, 32'h0, 1, 32'h0, 1'b1);
    xfer("mis.w2", 1'b1, 32'h3000_0002, 2'd2, 1'b0, 32'h5555_5555,
         0, 4'b0000, 32'h0, 1, 32'h0, 1'b1);
    xfer("mis.s3", 1'b0, 32'h3000_0000, 2'd3, 1'b0, 32'h0,
         0, 4'b0000, 32'h0, 1, 32'h0, 1'b1);
    // timeout after 4 silent bus cycles
    rsp_mode = 1;
    xfer("tmo", 1'b0, 32'h5000_0000, 2'd2, 1'b0, 32'h0,
         4, 4'b1111, 32'h0, 5, 32'h0, 1'b1);
    // ack and err together, then err alone
    rsp_mode = 2;
    xfer("ackerr", 1'b0, 32'h5000_0004, 2'd2, 1'b0, 32'h0,
         2, 4'b1111, 32'h0, 3, 32'h0, 1'b1);
    rsp_mode = 3;
    xfer("err", 1'b1, 32'h5000_0008, 2'd2, 1'b0, 32'h1111_2222,
         2, 4'b1111, 32'h1111_2222, 3, 32'h0, 1'b1);

    // reset during BUS
    rsp_mode = 1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h6000_0000;
    req_size = 2'd2; req_unsigned = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    chk("mrst.inbus", {30'd0, wb_cyc_o, wb_stb_o}, 32'd3);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst.cyc", {30'd0, wb_cyc_o, wb_stb_o}, 32'd0);
    chk("mrst.ready", {30'd0, resp_valid, req_ready}, 32'b01);
    rst = 1'b0;
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        if (resp_valid || wb_cyc_o) seen++;
      end
      chk("mrst.quiet", seen, 32'd0);
    end
    rsp_mode = 0;
    rsp_data = 32'hCAFE_F00D;
    xfer("mrst.lw", 1'b0, 32'h6000_0004, 2'd2, 1'b0, 32'h0,
         2, 4'b1111, 32'h0, 3, 32'hCAFE_F00D, 1'b0);

    // back-to-back with req_valid held high
    rsp_data = 32'h1122_3344;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h4000_0008;
    req_size = 2'd2; req_unsigned = 1'b0; req_wdata = 32'h0BAD_F00D;
    @(negedge clk);
    // cycle 1: first bus cycle; present the second request already
    chk("b2b.c1.cyc", {31'd0, wb_cyc_o}, 32'd1);
    chk("b2b.c1.adr", {2'd0, wb_adr_o}, 32'h1000_0002);
    chk("b2b.c1.sel", {28'd0, wb_sel_o}, 32'hF);
    req_we = 1'b0; req_addr = 32'h4000_000D; req_size = 2'd0; req_unsigned = 1'b1;
    @(negedge clk);
    chk("b2b.c2.cyc", {31'd0, wb_cyc_o}, 32'd1);
    @(negedge clk);
    chk("b2b.c3", {29'd0, wb_cyc_o, resp_valid, req_ready}, 32'b010);
    @(negedge clk);
    chk("b2b.c4", {29'd0, wb_cyc_o, resp_valid, req_ready}, 32'b001);
    @(negedge clk);
    chk("b2b.c5.cyc", {31'd0, wb_cyc_o}, 32'd1);
    chk("b2b.c5.adr", {2'd0, wb_adr_o}, 32'h1000_0003);
    chk("b2b.c5.sel", {28'd0, wb_sel_o}, 32'h2);
    chk("b2b.c5.we", {31'd0, wb_we_o}, 32'd0);
    @(negedge clk);
    chk("b2b.c6.cyc", {31'd0, wb_cyc_o}, 32'd1);
    @(negedge clk);
    chk("b2b.c7", {29'd0, wb_cyc_o, resp_valid, req_ready}, 32'b010);
    chk("b2b.c7.rdata", resp_rdata, 32'h0000_0033);
    req_valid = 1'b0;
    @(negedge clk);
    chk("b2b.c8", {29'd0, wb_cyc_o, resp_valid, req_ready}, 32'b001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wb_initiator.md
Name: wb_initiator

Overview:
- Wishbone classic single-transfer initiator (bus master).
- Accepts one load/store request at a time from a simple core-side request/response port. Drives one Wishbone classic cycle toward peripheral responders such as the LED driver, then returns aligned, extended read data.
- Generates byte lanes, detects misalignment and bus timeouts, and reports errors.

Parameters:
- TIMEOUT_CYCLES, 255: cycles in BUS without ack/err before the cycle is aborted with error; 0 disables the timeout.

Ports:
- clk  in  1  system clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  core presents a request
- req_ready  out  1  high only in IDLE; transfer accepted when req_valid & req_ready
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as an error
- req_unsigned  in  1  loads: zero-extend when 1, sign-extend when 0
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle pulse on completion
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  qualified by resp_valid
- wb_cyc_o  out  1  Wishbone cycle
- wb_stb_o  out  1  Wishbone strobe, identical to wb_cyc_o
- wb_we_o  out  1  write enable
- wb_adr_o  out  30  word address = req_addr[31:2]
- wb_sel_o  out  4  byte lane selects
- wb_dat_o  out  32  lane-replicated write data
- wb_dat_i  in  32  read data
- wb_ack_i  in  1  responder acknowledge
- wb_err_i  in  1  responder error

Behaviour:
- All outputs are registered. States: IDLE, BUS, RESP.
- Reset values: state IDLE, req_ready 1, resp_valid 0, resp_rdata 0, resp_err 0, wb_cyc_o/wb_stb_o/wb_we_o 0, wb_adr_o 0, wb_sel_o 0, wb_dat_o 0, timeout counter 0.
- IDLE, on accept: latch we, size, unsigned, addr[1:0].
  - Misaligned (half with addr[0] = 1, word with addr[1:0] != 0, or size 3): go to RESP with err = 1. No bus cycle occurs.
  - Otherwise: next cycle wb_cyc_o = wb_stb_o = 1; adr, sel, dat and we are valid and held stable until the cycle ends; go to BUS.
- Lane generation:
  - Byte: sel = 0001 << addr[1:0]; dat = {4{wdata[7:0]}}.
  - Half: sel = 0011 << (2*addr[1]); dat = {2{wdata[15:0]}}.
  - Word: sel = 1111; dat = wdata.
  - For loads, sel uses the same rule; dat = 0.
- BUS, counter increments every cycle.
  - wb_ack_i sampled high: capture wb_dat_i; drop cyc/stb on the next cycle; go to RESP with err = 0.
  - wb_err_i sampled high (priority over ack in the same cycle): drop cyc/stb; go to RESP with err = 1; rdata = 0.
  - Counter == TIMEOUT_CYCLES - 1 with no ack/err (TIMEOUT_CYCLES > 0): abort; go to RESP with err = 1.
- RESP: resp_valid = 1 for exactly one cycle; req_ready = 0; then IDLE with req_ready = 1.
  - Back-to-back requests therefore have a minimum gap of 1 idle cycle between cycles on the bus.
- Load extraction: select byte addr[1:0] or halfword addr[1] from the captured data, then zero-extend or sign-extend per req_unsigned. Word loads pass data through unchanged.
- Latency with a responder that acks 1 cycle after stb:
  - Cycle 0: accept.
  - Cycle 1: cyc/stb high.
  - Cycle 2: ack.
  - Cycle 3: resp_valid high, cyc/stb low.
- wb_cyc_o never deasserts before ack/err/timeout. The initiator never issues a new stb while the previous ack is in flight.
- rst asserted in any state, including mid-BUS: all outputs take their reset values on the next edge. The pending request is dropped and no response is produced.
- req_* inputs are ignored outside IDLE.

Test Plan:
1. Word store, addr 0x1000_0004, wdata 0xDEADBEEF, single-cycle-ack responder -> wb_adr_o = 0x0400_0001, sel = 1111, dat = 0xDEADBEEF, we = 1; resp_valid 3 cycles after accept with err = 0, rdata = 0.
2. Byte load, addr offset 3, responder returns 0x80AA_5511:
   - signed -> resp_rdata = 0xFFFF_FF80;
   - unsigned -> 0x0000_0080;
   - sel = 1000 in both cases.
3. Half store, addr offset 2, wdata 0x0000_1234 -> sel = 1100, dat = 0x1234_1234. Half load, offset 1 -> resp_err = 1 one cycle after accept, wb_cyc_o never asserted.
4. TIMEOUT_CYCLES = 4, responder never acks -> cyc/stb high exactly 4 cycles, then resp_valid with err = 1. wb_ack_i and wb_err_i asserted together -> err = 1.
5. rst pulsed during BUS -> cyc/stb low next cycle, no resp_valid, req_ready = 1. The following word load completes normally.
6. Two back-to-back requests with req_valid held high -> second accepted the cycle after resp_valid. Each bus cycle carries the correct adr/sel; cyc drops for ≥1 cycle between them.
